// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button event classifier.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND
    } btn_state_t;

    // Counter must hold the larger of the two thresholds.
    function automatic int cnt_width(input int long_cycles, input int gap_cycles);
        int m;
        m = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_event_edge_detect.sv
// Registered edge detector for a level already synchronous to clk.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic btn_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_prev <= 1'b0;
        else       btn_prev <= level;
    end

    assign rise = level & ~btn_prev;
    assign fall = ~level & btn_prev;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/short/long/double pulses.
//  state     | meaning
//  IDLE      | released, nothing pending
//  PRESSED   | first press held, timing toward long press
//  LONG_HELD | long press reported, waiting for release
//  WAIT_GAP  | first press released, waiting for a second press
//  SECOND    | second press of a double click held
module button_event
    import button_pkg::*;
#(
    parameter int LONG_CYCLES = 1000,
    parameter int GAP_CYCLES  = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse
);

    localparam int CW = cnt_width(LONG_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    generate
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("button_event: LONG_CYCLES must be >= 2");
        end
        if (GAP_CYCLES < 2) begin : g_bad_gap
            $error("button_event: GAP_CYCLES must be >= 2");
        end
    endgenerate

    btn_state_t    state, state_next;
    logic [CW-1:0] cnt;
    logic          rise, fall;
    logic          long_hit, gap_hit;
    logic          press_d, release_d, short_d, long_d, double_d;

    edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign long_hit = (cnt == LONG_LAST) &&  btn_in;
    assign gap_hit  = (cnt == GAP_LAST)  && !btn_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            double_pulse  <= 1'b0;
        end else begin
            state <= state_next;
            // Only the two timing states count; saturation keeps cnt from wrapping.
            if (state_next != state)
                cnt <= '0;
            else if ((state == PRESSED || state == WAIT_GAP) && cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            press_pulse   <= press_d;
            release_pulse <= release_d;
            short_pulse   <= short_d;
            long_pulse    <= long_d;
            double_pulse  <= double_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (rise) state_next = PRESSED;
            PRESSED: begin
                if (fall)          state_next = WAIT_GAP;
                else if (long_hit) state_next = LONG_HELD;
            end
            LONG_HELD: if (fall) state_next = IDLE;
            WAIT_GAP: begin
                if (rise)         state_next = SECOND;
                else if (gap_hit) state_next = IDLE;
            end
            SECOND:    if (fall) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // A rise at the gap-expiry edge wins over the short click.
    always_comb begin
        press_d   = rise;
        release_d = fall;
        long_d    = (state == PRESSED)  && long_hit;
        double_d  = (state == WAIT_GAP) && rise;
        short_d   = (state == WAIT_GAP) && !rise && gap_hit;
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: timestamp-based event model plus directed scenarios.
module tb_button_event;

    localparam int LONG = 8;
    localparam int GAP  = 4;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic press_pulse, release_pulse, short_pulse, long_pulse, double_pulse;

    always #5 clk = ~clk;

    button_event #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .double_pulse  (double_pulse)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model state: timestamps of the last rise/fall and what the current press is.
    int   edge_n = 0;
    logic m_prev = 1'b0;
    int   rise_at = 0, fall_at = 0;
    bit   pending = 0, is_second = 0, long_done = 1;
    bit   e_press, e_release, e_short, e_long, e_double;

    int n_press, n_release, n_short, n_long, n_double;
    int last_press, last_release, last_short, last_long, last_double;

    always @(posedge clk) begin
        logic b;
        edge_n++;
        e_press = 0; e_release = 0; e_short = 0; e_long = 0; e_double = 0;
        if (reset) begin
            m_prev = 0; pending = 0; is_second = 0; long_done = 1;
        end else begin
            b = btn_in;
            e_press   =  b && !m_prev;
            e_release = !b &&  m_prev;
            if (e_press) begin
                is_second = pending && (edge_n - fall_at <= GAP);
                e_double  = is_second;
                pending   = 0;
                rise_at   = edge_n;
                long_done = 0;
            end
            if (b && !is_second && !long_done && edge_n - rise_at == LONG) begin
                e_long    = 1;
                long_done = 1;
            end
            if (e_release && !is_second && !long_done) begin
                pending = 1;
                fall_at = edge_n;
            end
            if (pending && !b && edge_n - fall_at == GAP) begin
                e_short = 1;
                pending = 0;
            end
            m_prev = b;
        end
        #1;
        chk("press",   press_pulse,   e_press);
        chk("release", release_pulse, e_release);
        chk("short",   short_pulse,   e_short);
        chk("long",    long_pulse,    e_long);
        chk("double",  double_pulse,  e_double);
        if (press_pulse)   begin n_press++;   last_press   = edge_n; end
        if (release_pulse) begin n_release++; last_release = edge_n; end
        if (short_pulse)   begin n_short++;   last_short   = edge_n; end
        if (long_pulse)    begin n_long++;    last_long    = edge_n; end
        if (double_pulse)  begin n_double++;  last_double  = edge_n; end
    end

    task automatic step(input logic b);
        @(negedge clk);
        btn_in = b;
    endtask

    task automatic clear_rec();
        n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_double = 0;
        last_press = -1; last_release = -1; last_short = -1; last_long = -1; last_double = -1;
    endtask

    task automatic idle_reset();
        @(negedge clk);
        reset  = 1'b1;
        btn_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(1'b0);
        clear_rec();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_zero_outs"},
            {press_pulse, release_pulse, short_pulse, long_pulse, double_pulse}, 0);
    endtask

    initial begin
        int e0, f0, run;
        logic lvl;
        reset  = 1'b1;
        btn_in = 1'b0;
        clear_rec();
        #1;
        chk_outputs_zero("reset_initial");
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset_held");

        // Short click
        idle_reset();
        step(1'b1); e0 = edge_n + 1;
        repeat (2) step(1'b1);
        repeat (9) step(1'b0);
        chk("short_press_edge",   last_press,   e0);
        chk("short_release_edge", last_release, e0 + 3);
        chk("short_short_edge",   last_short,   e0 + 7);
        chk("short_short_cnt",    n_short,      1);
        chk("short_long_dbl_cnt", n_long + n_double, 0);

        // Long press
        idle_reset();
        step(1'b1); e0 = edge_n + 1;
        repeat (11) step(1'b1);
        repeat (8) step(1'b0);
        chk("long_long_cnt",     n_long,       1);
        chk("long_long_edge",    last_long,    e0 + 8);
        chk("long_release_edge", last_release, e0 + 12);
        chk("long_short_cnt",    n_short,      0);

        // Long boundary: released one edge too early
        idle_reset();
        step(1'b1); e0 = edge_n + 1;
        repeat (7) step(1'b1);
        repeat (8) step(1'b0);
        chk("bound_long_cnt",   n_long,     0);
        chk("bound_short_edge", last_short, e0 + 12);
        chk("bound_short_cnt",  n_short,    1);

        // Double click with second press on the gap-expiry edge
        idle_reset();
        step(1'b1); e0 = edge_n + 1;
        step(1'b1);
        repeat (4) step(1'b0);
        f0 = e0 + 2;
        step(1'b1);
        repeat (19) step(1'b1);
        repeat (8) step(1'b0);
        chk("dbl_double_edge", last_double, f0 + 4);
        chk("dbl_press_edge",  last_press,  f0 + 4);
        chk("dbl_counts",      {n_double[7:0], n_short[7:0], n_long[7:0], n_press[7:0]},
            {8'd1, 8'd0, 8'd0, 8'd2});

        // Reset while waiting for the gap
        idle_reset();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outputs_zero("rst_gap_async");
        @(negedge clk);
        chk_outputs_zero("rst_gap_held");
        reset = 1'b0;
        repeat (10) step(1'b0);
        chk("rst_gap_short_cnt",   n_short,   0);
        chk("rst_gap_release_cnt", n_release, 1);

        // Button held through reset release
        @(negedge clk);
        reset  = 1'b1;
        btn_in = 1'b1;
        @(negedge clk);
        clear_rec();
        reset = 1'b0;
        e0 = edge_n + 1;
        repeat (12) step(1'b1);
        repeat (3) step(1'b0);
        chk("held_press_edge", last_press, e0);
        chk("held_long_edge",  last_long,  e0 + 8);
        chk("held_long_cnt",   n_long,     1);

        // Random level runs with occasional resets, checked by the model every cycle
        lvl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                @(negedge clk);
                reset  = 1'b1;
                btn_in = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 1)) @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
            lvl = ~lvl;
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
            repeat (run) step(lvl);
        end
        repeat (20) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
